mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage access unit for the 5-stage MIPS pipeline. Replaces the combinational M-stage load/store decoder.
- Decodes lw/sw/lh/lhu/sh/lb/lbu/sb from the M-stage instruction and generates byte enables and replicated store data.
- Runs a req/gnt/rvalid bus handshake with a timeout, stalls the pipeline while a transfer is in flight, and returns sign- or zero-extended load data.
- Flags misaligned accesses (AdEL/AdES) and bus timeouts.

Parameters:
- ADDR_W, 32: address width. Must be 3 or more.
- TIMEOUT_CYC, 255: number of REQ+RESP cycles after which the bus is declared dead. Must be 1 or more.
- TO_W, 8: timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- instr  in  32  M-stage instruction.
- valid_m  in  1  M-stage instruction is valid (not bubble or flush).
- addr  in  ADDR_W  Byte address from the ALU.
- wdata  in  32  Store data from rt.
- stall_o  out  1  Freezes F/D/E/M; holds instr, addr and wdata stable.
- rdata_o  out  32  Extended load result, registered.
- rdata_valid  out  1  One-cycle strobe: rdata_o is valid for this instruction.
- exc_adel  out  1  Misaligned load (combinational).
- exc_ades  out  1  Misaligned store (combinational).
- exc_bus  out  1  One-cycle strobe on bus timeout.
- mem_req  out  1  Bus request, registered.
- mem_we  out  1  Write request.
- mem_addr  out  ADDR_W  Word-aligned address {addr[ADDR_W-1:2], 2'b00}.
- mem_be  out  4  Byte enables.
- mem_wdata  out  32  Replicated store data.
- mem_gnt  in  1  Request accepted this cycle.
- mem_rvalid  in  1  Read data valid.
- mem_rdata  in  32  Read word.

Behaviour:
- Decode uses op = instr[31:26]: lw 100011, sw 101011, sh 101001, sb 101000, lh 100001, lhu 100101, lb 100000, lbu 100100. memop = any of these AND valid_m.
- Alignment: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0; byte ops are always aligned.
  - exc_adel/exc_ades assert only in IDLE, when memop is misaligned.
  - A misaligned op starts no bus transaction and leaves stall_o=0.
- Byte enables:
  - sw: 1111.
  - sh: addr[1] ? 1100 : 0011.
  - sb: 0001 << addr[1:0].
  - loads: 0000.
- Store data: sh replicates wdata[15:0] twice; sb replicates wdata[7:0] four times; sw passes wdata unchanged.
- FSM states:
  - IDLE → REQ: on aligned memop. Latch op, addr[1:0], mem_addr, mem_be, mem_wdata and mem_we; clear the timeout counter.
  - REQ: mem_req=1 with latched fields held stable.
    - On mem_gnt, a store goes to DONE.
    - On mem_gnt, a load goes to RESP. If mem_rvalid is high in the same cycle, the load captures data and goes to DONE instead.
  - RESP: mem_req=0. On mem_rvalid, capture extended data into rdata_o and go to DONE.
  - DONE: lasts one cycle; always returns to IDLE. The pipeline advances this cycle, and the same instr is not re-issued.
- stall_o = (IDLE AND aligned memop) OR REQ OR RESP. It is 0 in DONE.
- Load extension uses little-endian byte lanes selected by the latched addr[1:0]:
  - lb: sign-extend byte.
  - lbu: zero-extend byte.
  - lh: sign-extend half at addr[1].
  - lhu: zero-extend half at addr[1].
  - lw: full word.
- rdata_valid=1 in DONE for loads only. rdata_o holds its value until the next load completes.
- Timeout: the counter increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYC with no completing event, go to DONE with exc_bus=1, rdata_o=0 and rdata_valid=0. A completing event in the same cycle wins over timeout.
- mem_gnt and mem_rvalid are ignored in IDLE and DONE. mem_rvalid is ignored in REQ before grant.
- Reset values: state IDLE; stall_o 0; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0; rdata_o 0; rdata_valid 0; exc_bus 0; counter 0.
- Reset mid-transfer: state goes to IDLE and mem_req drops at that edge. Late gnt/rvalid responses are discarded.

Test Plan:
- lbu then lb at addr 0x103, mem_rdata 0x80FF_1234, gnt and rvalid one cycle later each:
  - lbu → rdata_o=0x0000_0080; lb → 0xFFFF_FF80.
  - stall_o high for 3 cycles; rdata_valid for 1 cycle.
- sh at addr 0x102, wdata 0xDEAD_BEEF → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x100, mem_we=1. DONE follows the gnt cycle; rdata_valid=0.
- lw at 0x101 and sh at 0x103:
  - lw → exc_adel=1; sh → exc_ades=1.
  - mem_req stays 0 and stall_o 0 for both.
- Load with mem_gnt held low, TIMEOUT_CYC=4 → exactly 4 stalled REQ cycles, then exc_bus=1 for one cycle, rdata_o=0, return to IDLE.
- lh at 0x202 with gnt and rvalid in the same REQ cycle, mem_rdata 0x9000_0001 → rdata_o=0xFFFF_9000; RESP is skipped.
- reset asserted while in RESP, rvalid arriving 1 cycle later → state IDLE, mem_req 0, rdata_valid never asserts. valid_m=0 with a load opcode → no request.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes MIPS loads and stores, drives a req/gnt/rvalid
// bus with a timeout, stalls the pipeline during a transfer and extends load data.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              valid_m,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t         state, next_state;
    size_t          dec_size, size_q;
    logic           dec_load, dec_store, dec_sign, sign_q;
    logic           memop, misaligned, go;
    logic [3:0]     dec_be;
    logic [31:0]    dec_wdata;
    logic [1:0]     off_q;
    logic [TO_W-1:0] to_cnt;
    logic           busy, complete, to_hit, capture;

    // Sign or zero extension of the addressed little-endian lane.
    function automatic logic [31:0] extend(input size_t sz, input logic sgn,
                                           input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_B:    extend = {{24{sgn & b[7]}}, b};
            SZ_H:    extend = {{16{sgn & h[15]}}, h};
            default: extend = w;
        endcase
    endfunction

    // NOTE: every signal written in a combinational block gets a default first, so no path
    // through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        dec_load  = 1'b0;
        dec_store = 1'b0;
        dec_sign  = 1'b0;
        dec_size  = SZ_W;
        case (instr[31:26])
            6'b100011: begin dec_load  = 1'b1; dec_size = SZ_W; end
            6'b101011: begin dec_store = 1'b1; dec_size = SZ_W; end
            6'b101001: begin dec_store = 1'b1; dec_size = SZ_H; end
            6'b101000: begin dec_store = 1'b1; dec_size = SZ_B; end
            6'b100001: begin dec_load  = 1'b1; dec_size = SZ_H; dec_sign = 1'b1; end
            6'b100101: begin dec_load  = 1'b1; dec_size = SZ_H; end
            6'b100000: begin dec_load  = 1'b1; dec_size = SZ_B; dec_sign = 1'b1; end
            6'b100100: begin dec_load  = 1'b1; dec_size = SZ_B; end
            default:   ;
        endcase

        dec_be    = 4'b0000;
        dec_wdata = wdata;
        if (dec_store) begin
            case (dec_size)
                SZ_B: begin
                    dec_be    = 4'b0001 << addr[1:0];
                    dec_wdata = {4{wdata[7:0]}};
                end
                SZ_H: begin
                    dec_be    = addr[1] ? 4'b1100 : 4'b0011;
                    dec_wdata = {2{wdata[15:0]}};
                end
                default: dec_be = 4'b1111;
            endcase
        end
    end

    assign memop      = (dec_load | dec_store) & valid_m;
    assign misaligned = ((dec_size == SZ_W) && (addr[1:0] != 2'b00)) ||
                        ((dec_size == SZ_H) && addr[0]);
    assign go         = (state == S_IDLE) && memop && !misaligned;
    assign exc_adel   = (state == S_IDLE) && memop && dec_load  && misaligned;
    assign exc_ades   = (state == S_IDLE) && memop && dec_store && misaligned;
    assign stall_o    = go || (state == S_REQ) || (state == S_RESP);

    // A grant counts as progress, so it beats a timeout expiring in the same cycle.
    assign busy     = (state == S_REQ) || (state == S_RESP);
    assign complete = ((state == S_REQ) && mem_gnt) || ((state == S_RESP) && mem_rvalid);
    assign to_hit   = busy && (to_cnt >= TO_LAST) && !complete;
    assign capture  = !mem_we && (((state == S_REQ) && mem_gnt && mem_rvalid) ||
                                  ((state == S_RESP) && mem_rvalid));

    // NOTE: sequential state uses non-blocking assignments so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (go) next_state = S_REQ;
            S_REQ: begin
                if (mem_gnt)     next_state = (mem_we || mem_rvalid) ? S_DONE : S_RESP;
                else if (to_hit) next_state = S_DONE;
            end
            S_RESP: if (mem_rvalid || to_hit) next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            rdata_o     <= 32'h0;
            rdata_valid <= 1'b0;
            exc_bus     <= 1'b0;
            to_cnt      <= '0;
            off_q       <= 2'b00;
            size_q      <= SZ_W;
            sign_q      <= 1'b0;
        end else begin
            mem_req     <= (next_state == S_REQ);
            rdata_valid <= capture;
            exc_bus     <= to_hit;
            if (go) begin
                mem_we    <= dec_store;
                mem_be    <= dec_be;
                mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= dec_wdata;
                off_q     <= addr[1:0];
                size_q    <= dec_size;
                sign_q    <= dec_sign;
                to_cnt    <= '0;
            end else if (busy) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (capture)     rdata_o <= extend(size_q, sign_q, off_q, mem_rdata);
            else if (to_hit) rdata_o <= 32'h0;
        end
    end

endmodule
